// File: rtl/hart_sched_state_pkg.sv
// Shared definitions for the per-hart scheduling state unit.
// Holds the hart state encodings used by the state array and its decode.
package hart_sched_state_pkg;

    typedef enum logic [1:0] {
        HSTATE_IDLE   = 2'b00,
        HSTATE_ACTIVE = 2'b01,
        HSTATE_WAIT_I = 2'b10,
        HSTATE_WAIT_D = 2'b11
    } hstate_e;

endpackage

// File: rtl/hart_sched_state_rr_hart_sel.sv
// rr_hart_sel: combinational wrap-around priority search over a hart mask.
// Ports:
//   req    - request mask, one bit per hart
//   start  - index searched first; search proceeds upward and wraps to 0
//   gnt    - one-hot grant (zero when no request)
//   gnt_id - index of the granted hart (zero when no request)
//   vld    - at least one request was found
module rr_hart_sel #(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2
) (
    input  logic [HART_NUM-1:0]  req,
    input  logic [HART_ID_W-1:0] start,
    output logic [HART_NUM-1:0]  gnt,
    output logic [HART_ID_W-1:0] gnt_id,
    output logic                 vld
);

    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        vld    = 1'b0;
        idx    = 0;
        for (int k = 0; k < HART_NUM; k++) begin
            // Modulo keeps the search in range even when start equals HART_NUM
            // (prim_id+1 on a non power-of-two hart count).
            idx = (int'(start) + k) % HART_NUM;
            if (!vld && req[idx]) begin
                vld      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = HART_ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hart_sched_state.sv
// hart_sched_state: per-hart scheduling state and primary hart selection.
//
// state          | meaning
// ---------------+------------------------------------------
// HSTATE_IDLE    | hart not scheduled
// HSTATE_ACTIVE  | hart runnable, may be primary
// HSTATE_WAIT_I  | hart stalled on an I-cache refill
// HSTATE_WAIT_D  | hart stalled on a D-cache refill
//
// Ports:
//   clk, rst                 - clock, async active-high reset
//   set_hart/set_hstate/set_hart_val - activate (1) or idle (0) masked harts
//   i_cache_miss/if_hstate   - I-cache miss for masked ACTIVE harts
//   use_cache_miss/use_hstate - D-cache miss for masked ACTIVE harts
//   i_cache_fin/i_cache_fin_hstate - I refill done for masked WAIT_I harts
//   d_cache_fin/d_cache_fin_hstate - D refill done for masked WAIT_D harts
//   acti_hstate/wait_hstate/hart_idle_hstate - per-state hart masks
//   prim_hstate/prim_id      - one-hot primary hart and its index
//   prim_switch              - pulse when a new non-zero primary takes over
module hart_sched_state
    import hart_sched_state_pkg::*;
#(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2,
    parameter int BOOT_HART = 0,
    parameter int QUANTUM   = 16,
    parameter int QCNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_hart,
    input  logic [HART_NUM-1:0]  set_hstate,
    input  logic                 set_hart_val,
    input  logic                 i_cache_miss,
    input  logic [HART_NUM-1:0]  if_hstate,
    input  logic                 use_cache_miss,
    input  logic [HART_NUM-1:0]  use_hstate,
    input  logic                 i_cache_fin,
    input  logic [HART_NUM-1:0]  i_cache_fin_hstate,
    input  logic                 d_cache_fin,
    input  logic [HART_NUM-1:0]  d_cache_fin_hstate,
    output logic [HART_NUM-1:0]  acti_hstate,
    output logic [HART_NUM-1:0]  wait_hstate,
    output logic [HART_NUM-1:0]  hart_idle_hstate,
    output logic [HART_NUM-1:0]  prim_hstate,
    output logic [HART_ID_W-1:0] prim_id,
    output logic                 prim_switch
);

    hstate_e             st_q [HART_NUM];
    hstate_e             st_d [HART_NUM];
    logic [HART_NUM-1:0] nxt_acti;

    logic [HART_NUM-1:0]  nxt_prim;
    logic [HART_ID_W-1:0] nxt_prim_id;
    logic [QCNT_W-1:0]    qcnt_q;
    logic [QCNT_W-1:0]    qcnt_d;
    logic                 expire;
    logic                 keep_prim;
    logic                 switch_d;

    logic [HART_NUM-1:0]  rr_gnt;
    logic [HART_ID_W-1:0] rr_id;
    logic                 rr_vld;

    // Per-hart next state; set commands dominate, then misses on ACTIVE
    // harts (D before I), then fins matching the wait kind.
    always_comb begin
        nxt_acti = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            st_d[h] = st_q[h];
            if (set_hart && set_hstate[h]) begin
                if (!set_hart_val) begin
                    st_d[h] = HSTATE_IDLE;
                end else if (st_q[h] == HSTATE_IDLE) begin
                    st_d[h] = HSTATE_ACTIVE;
                end
            end else if (st_q[h] == HSTATE_ACTIVE) begin
                if (use_cache_miss && use_hstate[h]) begin
                    st_d[h] = HSTATE_WAIT_D;
                end else if (i_cache_miss && if_hstate[h]) begin
                    st_d[h] = HSTATE_WAIT_I;
                end
            end else if (st_q[h] == HSTATE_WAIT_I) begin
                if (i_cache_fin && i_cache_fin_hstate[h]) begin
                    st_d[h] = HSTATE_ACTIVE;
                end
            end else if (st_q[h] == HSTATE_WAIT_D) begin
                if (d_cache_fin && d_cache_fin_hstate[h]) begin
                    st_d[h] = HSTATE_ACTIVE;
                end
            end
            nxt_acti[h] = (st_d[h] == HSTATE_ACTIVE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < HART_NUM; h++) begin
                st_q[h] <= (h == BOOT_HART) ? HSTATE_ACTIVE : HSTATE_IDLE;
            end
        end else begin
            for (int h = 0; h < HART_NUM; h++) begin
                st_q[h] <= st_d[h];
            end
        end
    end

    always_comb begin
        acti_hstate      = '0;
        wait_hstate      = '0;
        hart_idle_hstate = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            acti_hstate[h]      = (st_q[h] == HSTATE_ACTIVE);
            wait_hstate[h]      = (st_q[h] == HSTATE_WAIT_I) || (st_q[h] == HSTATE_WAIT_D);
            hart_idle_hstate[h] = (st_q[h] == HSTATE_IDLE);
        end
    end

    // Searching from prim_id+1 puts the current primary last, so on expiry
    // another active hart wins if one exists; otherwise the current one is
    // re-granted and nothing changes.
    rr_hart_sel #(
        .HART_NUM  (HART_NUM),
        .HART_ID_W (HART_ID_W)
    ) u_rr_hart_sel (
        .req    (nxt_acti),
        .start  (prim_id + HART_ID_W'(1)),
        .gnt    (rr_gnt),
        .gnt_id (rr_id),
        .vld    (rr_vld)
    );

    always_comb begin
        expire      = (QUANTUM != 0) && (qcnt_q == QCNT_W'(QUANTUM - 1));
        keep_prim   = (prim_hstate != '0) && nxt_acti[prim_id] && !expire;
        nxt_prim    = prim_hstate;
        nxt_prim_id = prim_id;
        if (nxt_acti == '0) begin
            nxt_prim = '0;
        end else if (!keep_prim && rr_vld) begin
            nxt_prim    = rr_gnt;
            nxt_prim_id = rr_id;
        end

        qcnt_d = qcnt_q;
        if ((nxt_prim != prim_hstate) || (prim_hstate == '0)) begin
            qcnt_d = '0;
        end else if ((QUANTUM != 0) && !expire) begin
            qcnt_d = qcnt_q + QCNT_W'(1);
        end

        switch_d = (nxt_prim != prim_hstate) && (nxt_prim != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prim_hstate <= HART_NUM'(1) << BOOT_HART;
            prim_id     <= HART_ID_W'(BOOT_HART);
            qcnt_q      <= '0;
            prim_switch <= 1'b0;
        end else begin
            prim_hstate <= nxt_prim;
            prim_id     <= nxt_prim_id;
            qcnt_q      <= qcnt_d;
            prim_switch <= switch_d;
        end
    end

endmodule

// File: tb/tb_hart_sched_state.sv
// Directed bench for hart_sched_state with 4 harts, boot hart 2, quantum 4.
module tb_hart_sched_state;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_hart;
    logic [3:0] set_hstate;
    logic       set_hart_val;
    logic       i_cache_miss;
    logic [3:0] if_hstate;
    logic       use_cache_miss;
    logic [3:0] use_hstate;
    logic       i_cache_fin;
    logic [3:0] i_cache_fin_hstate;
    logic       d_cache_fin;
    logic [3:0] d_cache_fin_hstate;
    logic [3:0] acti_hstate;
    logic [3:0] wait_hstate;
    logic [3:0] hart_idle_hstate;
    logic [3:0] prim_hstate;
    logic [1:0] prim_id;
    logic       prim_switch;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    hart_sched_state #(
        .HART_NUM  (4),
        .HART_ID_W (2),
        .BOOT_HART (2),
        .QUANTUM   (4),
        .QCNT_W    (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .set_hart           (set_hart),
        .set_hstate         (set_hstate),
        .set_hart_val       (set_hart_val),
        .i_cache_miss       (i_cache_miss),
        .if_hstate          (if_hstate),
        .use_cache_miss     (use_cache_miss),
        .use_hstate         (use_hstate),
        .i_cache_fin        (i_cache_fin),
        .i_cache_fin_hstate (i_cache_fin_hstate),
        .d_cache_fin        (d_cache_fin),
        .d_cache_fin_hstate (d_cache_fin_hstate),
        .acti_hstate        (acti_hstate),
        .wait_hstate        (wait_hstate),
        .hart_idle_hstate   (hart_idle_hstate),
        .prim_hstate        (prim_hstate),
        .prim_id            (prim_id),
        .prim_switch        (prim_switch)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] ea, input logic [3:0] ew,
                             input logic [3:0] ei, input logic [3:0] ep,
                             input logic [1:0] eid, input logic esw);
        chk({tag, ".acti"}, 32'(acti_hstate), 32'(ea));
        chk({tag, ".wait"}, 32'(wait_hstate), 32'(ew));
        chk({tag, ".idle"}, 32'(hart_idle_hstate), 32'(ei));
        chk({tag, ".prim"}, 32'(prim_hstate), 32'(ep));
        chk({tag, ".prim_id"}, 32'(prim_id), 32'(eid));
        chk({tag, ".switch"}, 32'(prim_switch), 32'(esw));
    endtask

    task automatic clr_in();
        set_hart           = 1'b0;
        set_hstate         = 4'b0000;
        set_hart_val       = 1'b0;
        i_cache_miss       = 1'b0;
        if_hstate          = 4'b0000;
        use_cache_miss     = 1'b0;
        use_hstate         = 4'b0000;
        i_cache_fin        = 1'b0;
        i_cache_fin_hstate = 4'b0000;
        d_cache_fin        = 1'b0;
        d_cache_fin_hstate = 4'b0000;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_prim;
        logic [1:0] exp_id;
        logic       exp_sw;

        rst = 1'b1;
        clr_in();
        #12;
        rst = 1'b0;
        chk_state("reset", 4'b0100, 4'b0000, 4'b1011, 4'b0100, 2'd2, 1'b0);

        // Activate harts 0 and 1; hart 2 stays primary.
        set_hart = 1'b1; set_hstate = 4'b0011; set_hart_val = 1'b1;
        tick(); clr_in();
        chk_state("set_on", 4'b0111, 4'b0000, 4'b1000, 4'b0100, 2'd2, 1'b0);

        // Primary hart 2 misses in I-cache; next active above 2 wraps to hart 0.
        i_cache_miss = 1'b1; if_hstate = 4'b0100;
        tick(); clr_in();
        chk_state("imiss", 4'b0011, 4'b0100, 4'b1000, 4'b0001, 2'd0, 1'b1);

        // Quantum of 4 rotates between harts 0 and 1.
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_prim = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
            exp_id   = ((i / 4) % 2 == 0) ? 2'd0 : 2'd1;
            exp_sw   = (i % 4 == 0);
            chk($sformatf("rot%0d.prim", i), 32'(prim_hstate), 32'(exp_prim));
            chk($sformatf("rot%0d.prim_id", i), 32'(prim_id), 32'(exp_id));
            chk($sformatf("rot%0d.switch", i), 32'(prim_switch), 32'(exp_sw));
        end
        chk("rot.acti", 32'(acti_hstate), 32'(4'b0011));

        // Idle hart 1 and the waiting hart 2.
        set_hart = 1'b1; set_hstate = 4'b0110; set_hart_val = 1'b0;
        tick(); clr_in();
        chk_state("idle12", 4'b0001, 4'b0000, 4'b1110, 4'b0001, 2'd0, 1'b0);

        // Hart 0 D-misses; stale I fin for idled hart 2 is ignored.
        use_cache_miss = 1'b1; use_hstate = 4'b0001;
        i_cache_fin = 1'b1; i_cache_fin_hstate = 4'b0100;
        tick(); clr_in();
        chk_state("dmiss", 4'b0000, 4'b0001, 4'b1110, 4'b0000, 2'd0, 1'b0);

        // Wrong-kind fin on a WAIT_D hart is ignored.
        i_cache_fin = 1'b1; i_cache_fin_hstate = 4'b0001;
        tick(); clr_in();
        chk_state("ifin_ign", 4'b0000, 4'b0001, 4'b1110, 4'b0000, 2'd0, 1'b0);
        tick();
        chk_state("wait", 4'b0000, 4'b0001, 4'b1110, 4'b0000, 2'd0, 1'b0);

        d_cache_fin = 1'b1; d_cache_fin_hstate = 4'b0001;
        tick(); clr_in();
        chk_state("dfin", 4'b0001, 4'b0000, 4'b1110, 4'b0001, 2'd0, 1'b1);

        // Activate harts 1 and 3.
        set_hart = 1'b1; set_hstate = 4'b1010; set_hart_val = 1'b1;
        tick(); clr_in();
        chk_state("set13", 4'b1011, 4'b0000, 4'b0100, 4'b0001, 2'd0, 1'b0);

        // D and I miss on hart 1 together, hart 3 idled the same cycle.
        use_cache_miss = 1'b1; use_hstate = 4'b0010;
        i_cache_miss = 1'b1; if_hstate = 4'b0010;
        set_hart = 1'b1; set_hstate = 4'b1000; set_hart_val = 1'b0;
        tick(); clr_in();
        chk_state("dual", 4'b0001, 4'b0010, 4'b1100, 4'b0001, 2'd0, 1'b0);

        // Hart 1 is in WAIT_D, so an I fin leaves it waiting.
        i_cache_fin = 1'b1; i_cache_fin_hstate = 4'b0010;
        tick(); clr_in();
        chk_state("ifin_ign2", 4'b0001, 4'b0010, 4'b1100, 4'b0001, 2'd0, 1'b0);

        // Hart 1 returns as hart 0's quantum expires: primary rotates to hart 1.
        d_cache_fin = 1'b1; d_cache_fin_hstate = 4'b0010;
        tick(); clr_in();
        chk_state("dfin1", 4'b0011, 4'b0000, 4'b1100, 4'b0010, 2'd1, 1'b1);

        i_cache_miss = 1'b1; if_hstate = 4'b0001;
        tick(); clr_in();
        chk_state("imiss0", 4'b0010, 4'b0001, 4'b1100, 4'b0010, 2'd1, 1'b0);

        // Activate command on a waiting hart leaves it waiting.
        set_hart = 1'b1; set_hstate = 4'b0001; set_hart_val = 1'b1;
        tick(); clr_in();
        chk_state("set_wait", 4'b0010, 4'b0001, 4'b1100, 4'b0010, 2'd1, 1'b0);

        use_cache_miss = 1'b1; use_hstate = 4'b0010;
        tick(); clr_in();
        chk_state("both_wait", 4'b0000, 4'b0011, 4'b1100, 4'b0000, 2'd1, 1'b0);

        // Asynchronous reset between edges with a refill in flight.
        #2;
        rst = 1'b1;
        d_cache_fin = 1'b1; d_cache_fin_hstate = 4'b0010;
        #1;
        chk_state("async_rst", 4'b0100, 4'b0000, 4'b1011, 4'b0100, 2'd2, 1'b0);
        #1;
        rst = 1'b0;
        tick(); clr_in();
        chk_state("post_rst", 4'b0100, 4'b0000, 4'b1011, 4'b0100, 2'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
